rank_order_encoder: RTL and testbench
=====================================

Name: rank_order_encoder

Overview:
- Parametrised successor to the single-lane intensity sorter.
- Latches an image, then streams pixel indices in descending intensity order; equal intensities go in ascending index order.
- Scans SCAN_LANES pixels per cycle, stops at a programmable minimum intensity, and delivers each index to the AER input controller over a valid/ready handshake.
- Supports abort on inference completion.

Parameters:
- IMAGE_SIZE, 256, number of pixels (>=2).
- PIXEL_BITS, 8, pixel width; maximum intensity is 2^PIXEL_BITS-1.
- SCAN_LANES, 4, pixels compared per SCAN cycle (1..IMAGE_SIZE); need not divide IMAGE_SIZE.
- INDEX_BITS, $clog2(IMAGE_SIZE), width of an emitted index.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- IMAGE  in  IMAGE_SIZE*PIXEL_BITS  flat image; pixel i at bits [i*PIXEL_BITS +: PIXEL_BITS].
- MIN_INTENSITY  in  PIXEL_BITS  lowest intensity emitted; sampled with NEW_IMAGE.
- NEW_IMAGE  in  1  start pulse; honoured only in IDLE.
- ABORT  in  1  cancel the current encode (driven from INFERENCE_DONE).
- INDEX_READY  in  1  consumer ready (= !AERIN_CTRL_BUSY at top level).
- NEXT_INDEX  out  INDEX_BITS  emitted pixel index.
- INDEX_VALID  out  1  NEXT_INDEX valid.
- BUSY  out  1  high in every state except IDLE.
- IMAGE_ENCODED  out  1  one-cycle pulse on normal completion.

Behaviour:
- Single clock CLK. Reset is synchronous and active-high on RST.
- Reset values: all outputs 0, state IDLE; internal image and pointers cleared.
- Internal registers:
  - image_q and thr_q.
  - intensity: PIXEL_BITS wide.
  - pixel_ptr: INDEX_BITS+1 wide.
  - hit_idx.
  - emitted: INDEX_BITS+1 wide.
- IDLE:
  - On NEW_IMAGE: image_q<=IMAGE, thr_q<=MIN_INTENSITY, intensity<=all ones, pixel_ptr<=0, emitted<=0, go to SCAN.
  - NEW_IMAGE is ignored in all other states.
- SCAN:
  - Window is lanes pixel_ptr..pixel_ptr+SCAN_LANES-1; lanes at or above IMAGE_SIZE are masked.
  - If any unmasked lane has image_q == intensity: hit_idx <= lowest matching index, NEXT_INDEX <= hit_idx, INDEX_VALID <= 1, go to EMIT.
  - Else if pixel_ptr+SCAN_LANES >= IMAGE_SIZE: go to NEXT_LEVEL.
  - Else: pixel_ptr += SCAN_LANES.
- EMIT:
  - NEXT_INDEX and INDEX_VALID stay stable until INDEX_READY is high.
  - On the handshake cycle: INDEX_VALID <= 0, emitted <= emitted+1.
  - If emitted == IMAGE_SIZE-1: go to DONE.
  - Else if hit_idx == IMAGE_SIZE-1: go to NEXT_LEVEL.
  - Else: pixel_ptr <= hit_idx+1, go to SCAN.
  - There is no combinational path from INDEX_READY to INDEX_VALID.
- NEXT_LEVEL:
  - If intensity == thr_q: go to DONE. This also prevents wrap-around below 0.
  - Else: intensity -= 1, pixel_ptr <= 0, go to SCAN.
- DONE: IMAGE_ENCODED = 1 for exactly one cycle, then go to IDLE.
- ABORT:
  - When high in any non-IDLE state, go to IDLE next cycle with INDEX_VALID = 0 and no IMAGE_ENCODED pulse.
  - ABORT beats a simultaneous handshake; that index counts as not delivered.
- RST mid-operation behaves the same as ABORT, plus all registers are reset.
- Latency:
  - NEW_IMAGE in cycle T; a matching hit in the first window gives INDEX_VALID at T+2.
  - Each empty window costs 1 cycle; each emitted index costs at least 2 cycles (SCAN, EMIT).
  - Worst case = levels*ceil(IMAGE_SIZE/SCAN_LANES) + 2*IMAGE_SIZE + levels + 2 cycles.
- Each index is emitted at most once per image; indices never repeat.

Optional Feature:
- RANK_ORDER_ENCODER_COUNT_EN defined:
  - Adds output EMIT_COUNT, INDEX_BITS+1 wide.
  - Holds the number of completed handshakes for the current image.
  - Cleared on NEW_IMAGE acceptance and on RST; held (not cleared) after DONE or ABORT.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. IMAGE_SIZE=8, SCAN_LANES=4, pixels [10,200,200,0,255,10,3,255], MIN_INTENSITY=0, INDEX_READY=1 -> indices 4,7,1,2,0,5,6,3; IMAGE_ENCODED pulses once, one cycle after the last handshake; BUSY then 0.
2. Same image, MIN_INTENSITY=10 -> indices 4,7,1,2,0,5 only; IMAGE_ENCODED pulses; 6 and 3 are never emitted.
3. Test 1 with INDEX_READY held low for 5 cycles at each VALID -> NEXT_INDEX stable while stalled; same 8-index order; no loss or duplication.
4. ABORT after the 3rd handshake -> INDEX_VALID 0 and BUSY 0 next cycle, no IMAGE_ENCODED; a following NEW_IMAGE restarts at intensity 255 and emits the full sequence from 4.
5. IMAGE_SIZE=6, SCAN_LANES=4, all pixels 0, MIN_INTENSITY=0 -> all 256 levels walked; indices 0..5 in order; lanes 6,7 never match; IMAGE_ENCODED after index 5.
6. RST asserted while in EMIT -> next cycle all outputs 0, state IDLE, NEW_IMAGE accepted on the following cycle; with RANK_ORDER_ENCODER_COUNT_EN defined, EMIT_COUNT = 0.

Source files
------------

// File: rtl/rank_order_encoder.sv
// Streams pixel indices of a latched image in descending intensity order (ties by ascending index),
// scanning SCAN_LANES pixels per cycle. Define RANK_ORDER_ENCODER_COUNT_EN to add the EMIT_COUNT output.
module rank_order_encoder #(
    parameter int unsigned IMAGE_SIZE = 256,
    parameter int unsigned PIXEL_BITS = 8,
    parameter int unsigned SCAN_LANES = 4,
    parameter int unsigned INDEX_BITS = $clog2(IMAGE_SIZE)
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [IMAGE_SIZE*PIXEL_BITS-1:0] IMAGE,
    input  logic [PIXEL_BITS-1:0]            MIN_INTENSITY,
    input  logic                             NEW_IMAGE,
    input  logic                             ABORT,
    input  logic                             INDEX_READY,
    output logic [INDEX_BITS-1:0]            NEXT_INDEX,
    output logic                             INDEX_VALID,
    output logic                             BUSY,
`ifdef RANK_ORDER_ENCODER_COUNT_EN
    output logic [INDEX_BITS:0]              EMIT_COUNT,
`endif
    output logic                             IMAGE_ENCODED
);

    localparam int unsigned PTR_W = INDEX_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_NEXT_LEVEL,
        S_DONE
    } state_t;

    state_t                           state, state_d;
    logic [IMAGE_SIZE*PIXEL_BITS-1:0] image_q, image_d;
    logic [PIXEL_BITS-1:0]            thr_q, thr_d;
    logic [PIXEL_BITS-1:0]            intensity, intensity_d;
    logic [PTR_W-1:0]                 pixel_ptr, pixel_ptr_d;
    logic [INDEX_BITS-1:0]            hit_idx, hit_idx_d;
    logic [PTR_W-1:0]                 emitted, emitted_d;
    logic [INDEX_BITS-1:0]            next_index_q, next_index_d;
    logic                             valid_q, valid_d;

    logic                             win_hit;
    logic [INDEX_BITS-1:0]            win_idx;
    logic                             win_last;

    // Lanes past the end of the image are masked so they can never produce a hit.
    always_comb begin
        int unsigned lane;
        win_hit = 1'b0;
        win_idx = '0;
        lane    = 0;
        for (int unsigned l = 0; l < SCAN_LANES; l++) begin
            lane = 32'(pixel_ptr) + l;
            if (!win_hit && lane < IMAGE_SIZE) begin
                if (image_q[lane*PIXEL_BITS +: PIXEL_BITS] == intensity) begin
                    win_hit = 1'b1;
                    win_idx = INDEX_BITS'(lane);
                end
            end
        end
        win_last = (32'(pixel_ptr) + SCAN_LANES >= IMAGE_SIZE);
    end

    always_comb begin
        state_d      = state;
        image_d      = image_q;
        thr_d        = thr_q;
        intensity_d  = intensity;
        pixel_ptr_d  = pixel_ptr;
        hit_idx_d    = hit_idx;
        emitted_d    = emitted;
        next_index_d = next_index_q;
        valid_d      = valid_q;

        case (state)
            S_IDLE: begin
                if (NEW_IMAGE) begin
                    image_d     = IMAGE;
                    thr_d       = MIN_INTENSITY;
                    intensity_d = '1;
                    pixel_ptr_d = '0;
                    emitted_d   = '0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (win_hit) begin
                    hit_idx_d    = win_idx;
                    next_index_d = win_idx;
                    valid_d      = 1'b1;
                    state_d      = S_EMIT;
                end else if (win_last) begin
                    state_d = S_NEXT_LEVEL;
                end else begin
                    pixel_ptr_d = pixel_ptr + PTR_W'(SCAN_LANES);
                end
            end
            S_EMIT: begin
                if (INDEX_READY) begin
                    valid_d   = 1'b0;
                    emitted_d = emitted + PTR_W'(1);
                    if (emitted == PTR_W'(IMAGE_SIZE - 1)) begin
                        state_d = S_DONE;
                    end else if (hit_idx == INDEX_BITS'(IMAGE_SIZE - 1)) begin
                        state_d = S_NEXT_LEVEL;
                    end else begin
                        pixel_ptr_d = {1'b0, hit_idx} + PTR_W'(1);
                        state_d     = S_SCAN;
                    end
                end
            end
            S_NEXT_LEVEL: begin
                // Stopping at the threshold also keeps intensity from wrapping below zero.
                if (intensity == thr_q) begin
                    state_d = S_DONE;
                end else begin
                    intensity_d = intensity - PIXEL_BITS'(1);
                    pixel_ptr_d = '0;
                    state_d     = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over a simultaneous handshake: that index is not counted as delivered.
        if (ABORT && state != S_IDLE) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            emitted_d = emitted;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            image_q      <= '0;
            thr_q        <= '0;
            intensity    <= '0;
            pixel_ptr    <= '0;
            hit_idx      <= '0;
            emitted      <= '0;
            next_index_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            state        <= state_d;
            image_q      <= image_d;
            thr_q        <= thr_d;
            intensity    <= intensity_d;
            pixel_ptr    <= pixel_ptr_d;
            hit_idx      <= hit_idx_d;
            emitted      <= emitted_d;
            next_index_q <= next_index_d;
            valid_q      <= valid_d;
        end
    end

    assign NEXT_INDEX    = next_index_q;
    assign INDEX_VALID   = valid_q;
    assign BUSY          = (state != S_IDLE);
    assign IMAGE_ENCODED = (state == S_DONE);

`ifdef RANK_ORDER_ENCODER_COUNT_EN
    assign EMIT_COUNT = emitted;
`endif

endmodule

// File: tb/tb_rank_order_encoder.sv
// Scoreboard bench for rank_order_encoder: an 8-pixel instance for ordering, thresholds, stalls,
// abort and reset, and a 6-pixel instance for the partial-window full level walk.
module tb_rank_order_encoder;

    logic        clk;
    logic        rst;

    logic [63:0] img8;
    logic [7:0]  min8;
    logic        new8, abort8, rdy8;
    logic [2:0]  idx8;
    logic        v8, busy8, enc8;

    logic [47:0] img6;
    logic [7:0]  min6;
    logic        new6, abort6, rdy6;
    logic [2:0]  idx6;
    logic        v6, busy6, enc6;

`ifdef RANK_ORDER_ENCODER_COUNT_EN
    logic [3:0]  cnt8, cnt6;
`endif

    int total = 0;
    int bad   = 0;

    int sb8[$];
    int sb6[$];
    int hs8 = 0, hs6 = 0;
    int enc8_n = 0, enc6_n = 0;
    int cyc = 0;
    int last_hs = -10;
    bit enc_after_hs = 1'b0;
    bit stall_mode = 1'b0;

    localparam logic [63:0] IMG_A = {8'd255, 8'd3, 8'd10, 8'd255, 8'd0, 8'd200, 8'd200, 8'd10};
    int order_a[8] = '{4, 7, 1, 2, 0, 5, 6, 3};

    rank_order_encoder #(
        .IMAGE_SIZE(8),
        .PIXEL_BITS(8),
        .SCAN_LANES(4)
    ) dut8 (
        .CLK(clk),
        .RST(rst),
        .IMAGE(img8),
        .MIN_INTENSITY(min8),
        .NEW_IMAGE(new8),
        .ABORT(abort8),
        .INDEX_READY(rdy8),
        .NEXT_INDEX(idx8),
        .INDEX_VALID(v8),
        .BUSY(busy8),
`ifdef RANK_ORDER_ENCODER_COUNT_EN
        .EMIT_COUNT(cnt8),
`endif
        .IMAGE_ENCODED(enc8)
    );

    rank_order_encoder #(
        .IMAGE_SIZE(6),
        .PIXEL_BITS(8),
        .SCAN_LANES(4)
    ) dut6 (
        .CLK(clk),
        .RST(rst),
        .IMAGE(img6),
        .MIN_INTENSITY(min6),
        .NEW_IMAGE(new6),
        .ABORT(abort6),
        .INDEX_READY(rdy6),
        .NEXT_INDEX(idx6),
        .INDEX_VALID(v6),
        .BUSY(busy6),
`ifdef RANK_ORDER_ENCODER_COUNT_EN
        .EMIT_COUNT(cnt6),
`endif
        .IMAGE_ENCODED(enc6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ready driver: when stalling, hold ready low for 5 cycles of every valid index.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        rdy8 = 1'b1;
        forever begin
            @(negedge clk);
            if (!stall_mode) begin
                rdy8 = 1'b1;
                stall_cnt = 0;
            end else if (v8) begin
                if (stall_cnt < 5) begin
                    rdy8 = 1'b0;
                    stall_cnt++;
                end else begin
                    rdy8 = 1'b1;
                end
            end else begin
                rdy8 = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor for the 8-pixel instance.
    initial begin
        bit   pend;
        int   prev_idx;
        int   e;
        pend = 1'b0;
        prev_idx = 0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("stall_valid_held", v8, 1);
                    chk("stall_index_held", idx8, prev_idx);
                end
                pend = v8 && !rdy8 && !abort8;
                prev_idx = idx8;
                if (v8 && rdy8 && !abort8) begin
                    if (sb8.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_index8: got %0d, expected none", idx8);
                    end else begin
                        e = sb8.pop_front();
                        chk("index8", idx8, e);
                    end
                    hs8++;
                    last_hs = cyc;
                end
                if (enc8) begin
                    enc8_n++;
                    if (enc_after_hs) chk("encoded_after_last_hs", cyc - last_hs, 1);
                end
            end
        end
    end

    // Monitor for the 6-pixel instance.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (v6 && rdy6 && !abort6) begin
                    if (sb6.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_index6: got %0d, expected none", idx6);
                    end else begin
                        e = sb6.pop_front();
                        chk("index6", idx6, e);
                    end
                    hs6++;
                end
                if (enc6) enc6_n++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic start8(input logic [63:0] img, input logic [7:0] mn);
        @(negedge clk);
        img8 = img;
        min8 = mn;
        new8 = 1'b1;
        @(negedge clk);
        new8 = 1'b0;
        img8 = '1;
    endtask

    task automatic wait_idle8(input int budget, input string nm);
        int i;
        i = 0;
        while (busy8 && i < budget) begin
            @(negedge clk);
            #2;
            i++;
        end
        chk(nm, busy8, 0);
    endtask

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) sb8.push_back(order_a[i]);
    endtask

    initial begin
        int e0, h0, i;
        rst = 1'b1;
        img8 = '0; min8 = '0; new8 = 1'b0; abort8 = 1'b0;
        img6 = '0; min6 = '0; new6 = 1'b0; abort6 = 1'b0; rdy6 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", v8, 0);
        chk("reset_busy", busy8, 0);
        chk("reset_encoded", enc8, 0);
        chk("reset_index", idx8, 0);
        rst = 1'b0;

        // 1: full descending order, always ready
        enc_after_hs = 1'b1;
        e0 = enc8_n;
        push_a(8);
        start8(IMG_A, 8'd0);
        chk("t1_busy_after_start", busy8, 1);
        wait_idle8(2000, "t1_finish");
        chk("t1_encoded_pulses", enc8_n - e0, 1);
        chk("t1_sb_empty", sb8.size(), 0);
`ifdef RANK_ORDER_ENCODER_COUNT_EN
        chk("t1_emit_count", cnt8, 8);
`endif

        // 2: threshold 10 stops before intensities 3 and 0
        enc_after_hs = 1'b0;
        e0 = enc8_n;
        push_a(6);
        start8(IMG_A, 8'd10);
        wait_idle8(2000, "t2_finish");
        chk("t2_encoded_pulses", enc8_n - e0, 1);
        chk("t2_sb_empty", sb8.size(), 0);
`ifdef RANK_ORDER_ENCODER_COUNT_EN
        chk("t2_emit_count", cnt8, 6);
`endif

        // 3: consumer stalls 5 cycles per index; a mid-run NEW_IMAGE must be ignored
        enc_after_hs = 1'b1;
        stall_mode = 1'b1;
        e0 = enc8_n;
        push_a(8);
        start8(IMG_A, 8'd0);
        repeat (10) @(negedge clk);
        img8 = '0;
        new8 = 1'b1;
        @(negedge clk);
        new8 = 1'b0;
        wait_idle8(3000, "t3_finish");
        chk("t3_encoded_pulses", enc8_n - e0, 1);
        chk("t3_sb_empty", sb8.size(), 0);
        stall_mode = 1'b0;
        @(negedge clk);

        // 4: abort after the third handshake, then restart from the top
        e0 = enc8_n;
        h0 = hs8;
        push_a(3);
        start8(IMG_A, 8'd0);
        i = 0;
        while (hs8 < h0 + 3 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk("t4_three_handshakes", hs8 - h0, 3);
        abort8 = 1'b1;
        @(negedge clk);
        #2;
        chk("t4_abort_valid", v8, 0);
        chk("t4_abort_busy", busy8, 0);
        abort8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_no_encoded", enc8_n - e0, 0);
        chk("t4_sb_empty", sb8.size(), 0);
`ifdef RANK_ORDER_ENCODER_COUNT_EN
        chk("t4_emit_count_held", cnt8, 3);
`endif
        e0 = enc8_n;
        push_a(8);
        start8(IMG_A, 8'd0);
        wait_idle8(2000, "t4_restart_finish");
        chk("t4_restart_encoded", enc8_n - e0, 1);
        chk("t4_restart_sb_empty", sb8.size(), 0);

        // 6: reset while an index is presented, then an immediate restart with latency check
        e0 = enc8_n;
        start8(IMG_A, 8'd0);
        i = 0;
        while (!v8 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("t6_reach_emit", v8, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", v8, 0);
        chk("t6_rst_busy", busy8, 0);
        chk("t6_rst_encoded", enc8, 0);
        chk("t6_rst_index", idx8, 0);
`ifdef RANK_ORDER_ENCODER_COUNT_EN
        chk("t6_rst_emit_count", cnt8, 0);
`endif
        rst = 1'b0;
        push_a(8);
        img8 = IMG_A;
        min8 = 8'd0;
        new8 = 1'b1;
        @(negedge clk);
        new8 = 1'b0;
        chk("t6_busy_T1", busy8, 1);
        chk("t6_valid_T1", v8, 0);
        @(negedge clk);
        chk("t6_valid_T2_empty_window", v8, 0);
        @(negedge clk);
        chk("t6_valid_T3", v8, 1);
        chk("t6_first_index", idx8, 4);
        wait_idle8(2000, "t6_finish");
        chk("t6_encoded", enc8_n - e0, 1);
        chk("t6_sb_empty", sb8.size(), 0);

        // 5: 6-pixel image of zeros, partial last window, all 256 levels walked
        e0 = enc6_n;
        for (int k = 0; k < 6; k++) sb6.push_back(k);
        @(negedge clk);
        img6 = '0;
        min6 = 8'd0;
        new6 = 1'b1;
        @(negedge clk);
        new6 = 1'b0;
        chk("t5_busy", busy6, 1);
        i = 0;
        while (busy6 && i < 3000) begin
            @(negedge clk);
            #2;
            i++;
        end
        chk("t5_finish", busy6, 0);
        chk("t5_encoded", enc6_n - e0, 1);
        chk("t5_sb_empty", sb6.size(), 0);
        chk("t5_walk_length_min", (i > 700) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
